// File: rtl/life_draw_unit.sv
// Lives-indicator draw engine: on enable, streams one pixel per cycle for a row
// of icon slots (live slots in COLOUR, the rest erased), then holds drawEnd.
module life_draw_unit #(
  parameter int         ICON_W    = 8,
  parameter int         ICON_H    = 4,
  parameter int         GAP       = 2,
  parameter int         ORIGIN_X  = 4,
  parameter int         ORIGIN_Y  = 112,
  parameter int         MAX_LIVES = 9,
  parameter logic [2:0] COLOUR    = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drawEnable,
  input  logic       drawReset,
  input  logic [3:0] lives,
  output logic       drawEnd,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam int COL_W  = (ICON_W > 1) ? $clog2(ICON_W) : 1;
  localparam int ROW_W  = (ICON_H > 1) ? $clog2(ICON_H) : 1;
  localparam int SLOT_W = (MAX_LIVES > 1) ? $clog2(MAX_LIVES) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ICON_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ICON_H - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(MAX_LIVES - 1);
  localparam logic [3:0]        LIVES_CAP = 4'(MAX_LIVES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [SLOT_W-1:0] slot;
  logic [3:0]        livesLatched;

  logic [7:0] pixX;
  logic [6:0] pixY;
  logic [2:0] pixColour;
  logic       lastPixel;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pixX      = 8'(ORIGIN_X + int'(slot) * (ICON_W + GAP) + int'(col));
    pixY      = 7'(ORIGIN_Y + int'(row));
    pixColour = (int'(slot) < int'(livesLatched)) ? COLOUR : BG_COLOUR;
    lastPixel = (col == COL_LAST) && (row == ROW_LAST) && (slot == SLOT_LAST);
  end

  assign drawEnd = (state == DONE);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || drawReset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      slot         <= '0;
      livesLatched <= '0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      plot         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (drawEnable) begin
            livesLatched <= (lives > LIVES_CAP) ? LIVES_CAP : lives;
            col          <= '0;
            row          <= '0;
            slot         <= '0;
            state        <= DRAW;
          end
        end
        DRAW: begin
          if (drawEnable) begin
            x      <= pixX;
            y      <= pixY;
            colour <= pixColour;
            plot   <= 1'b1;
            // Raster order: col fastest, then row, then slot.
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row  <= '0;
                slot <= lastPixel ? '0 : slot + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
            if (lastPixel) state <= DONE;
          end else begin
            plot <= 1'b0;
          end
        end
        DONE: plot <= 1'b0;
        default: begin
          plot  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
